// File: rtl/punc_mem_arbiter_pkg.sv
// Shared types and constants for the PUnC memory-port arbiter.
// Owner encoding: idle = 2'b00, CPU = 2'b01, debug/loader = 2'b10.
// The last-served flag names the port that most recently gave up the memory port.
package punc_mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int WAIT_W     = 16;
    localparam logic [WAIT_W-1:0] WAIT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_CPU  = 2'b01,
        ARB_DBG  = 2'b10
    } arb_owner_t;

    typedef enum logic {
        ARB_SRV_CPU = 1'b0,
        ARB_SRV_DBG = 1'b1
    } arb_srv_t;

    // Converts the owner that is leaving into the matching last-served tag.
    function automatic arb_srv_t srv_of(arb_owner_t o);
        return (o == ARB_DBG) ? ARB_SRV_DBG : ARB_SRV_CPU;
    endfunction

endpackage

// File: rtl/punc_mem_arbiter_if.sv
// One requester-side memory port: the request/lock/data signals and the grant/read data that come back.
// The master modport belongs to a requester (CPU or debug loader).
// The slave modport belongs to the arbiter.
interface punc_mem_port_if
    import punc_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req;
    logic              lock;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, lock, wr_en, addr, wdata,
        input  gnt, rdata
    );

    modport slave (
        input  req, lock, wr_en, addr, wdata,
        output gnt, rdata
    );
endinterface

// File: rtl/punc_mem_arbiter_wait_cnt.sv
// 16-bit saturating counter that records how many cycles a port spent waiting for a grant.
// A synchronous clear has priority over counting.
module punc_arb_wait_cnt
    import punc_mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              en,
    output logic [WAIT_W-1:0] count
);

    // Count enabled cycles; hold the count once it reaches the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (en && (count != WAIT_MAX)) begin
            count <= count + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/punc_mem_arbiter.sv
// Arbitrates the single PUnC memory port between the CPU and the debug/loader port.
// The owner is a registered state. Ties are broken round-robin.
// A lock holds ownership across multi-cycle operations.
// A burst limit makes a long-running owner yield to a waiting peer.
// Optional build macro PUNC_ARB_STATS_EN adds per-port saturating wait-cycle counters.
module punc_mem_arbiter
    import punc_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    punc_mem_port_if.slave    cpu,
    punc_mem_port_if.slave    dbg,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef PUNC_ARB_STATS_EN
    ,
    output logic [WAIT_W-1:0] cpu_wait_cnt,
    output logic [WAIT_W-1:0] dbg_wait_cnt
`endif
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [CNT_W-1:0] BURST_TOP  = CNT_W'(BURST_MAX);

    arb_owner_t       owner, owner_next;
    arb_srv_t         last_srv;
    logic [CNT_W-1:0] burst_cnt;
    logic             burst_done;

    // The burst counter can already be saturated when a peer shows up, for example after
    // a lock or a long unopposed run. Using ">=" instead of "==" therefore still yields.
    assign burst_done = (burst_cnt >= BURST_LAST);

    // Next-owner decision: tie-break from idle, lock hold, release on dropped request, burst yield.
    always_comb begin
        owner_next = owner;
        unique case (owner)
            ARB_IDLE: begin
                if (cpu.req && dbg.req) begin
                    owner_next = (last_srv == ARB_SRV_CPU) ? ARB_DBG : ARB_CPU;
                end else if (cpu.req) begin
                    owner_next = ARB_CPU;
                end else if (dbg.req) begin
                    owner_next = ARB_DBG;
                end
            end
            ARB_CPU: begin
                if (cpu.req && cpu.lock) begin
                    owner_next = ARB_CPU;
                end else if (!cpu.req) begin
                    owner_next = dbg.req ? ARB_DBG : ARB_IDLE;
                end else if (burst_done && dbg.req) begin
                    owner_next = ARB_DBG;
                end
            end
            ARB_DBG: begin
                if (dbg.req && dbg.lock) begin
                    owner_next = ARB_DBG;
                end else if (!dbg.req) begin
                    owner_next = cpu.req ? ARB_CPU : ARB_IDLE;
                end else if (burst_done && cpu.req) begin
                    owner_next = ARB_CPU;
                end
            end
            default: owner_next = ARB_IDLE;
        endcase
    end

    // Owner register, last-served tag, and a burst counter that restarts on every handover.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner     <= ARB_IDLE;
            last_srv  <= ARB_SRV_DBG;
            burst_cnt <= '0;
        end else begin
            owner <= owner_next;
            if (owner_next != owner) begin
                burst_cnt <= '0;
                if (owner != ARB_IDLE) begin
                    last_srv <= srv_of(owner);
                end
            end else if ((owner != ARB_IDLE) && (burst_cnt != BURST_TOP)) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end
    end

    // Route the owner's address and data to memory; the CPU side is the default while idle.
    // The write enable is blocked while reset is asserted.
    always_comb begin
        mem_addr  = cpu.addr;
        mem_wdata = cpu.wdata;
        mem_wr_en = 1'b0;
        if (owner == ARB_DBG) begin
            mem_addr  = dbg.addr;
            mem_wdata = dbg.wdata;
            mem_wr_en = dbg.req & dbg.wr_en;
        end else if (owner == ARB_CPU) begin
            mem_wr_en = cpu.req & cpu.wr_en;
        end
        if (!rst_n) begin
            mem_wr_en = 1'b0;
        end
    end

    assign cpu.gnt   = (owner == ARB_CPU);
    assign dbg.gnt   = (owner == ARB_DBG);
    assign cpu.rdata = mem_rdata;
    assign dbg.rdata = mem_rdata;
    assign cpu_stall = cpu.req & ~cpu.gnt;

`ifdef PUNC_ARB_STATS_EN
    punc_arb_wait_cnt u_cpu_wait (
        .clk   (clk),
        .clear (~rst_n),
        .en    (cpu.req & ~cpu.gnt),
        .count (cpu_wait_cnt)
    );

    punc_arb_wait_cnt u_dbg_wait (
        .clk   (clk),
        .clear (~rst_n),
        .en    (dbg.req & ~dbg.gnt),
        .count (dbg_wait_cnt)
    );
`endif

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Self-checking bench for punc_mem_arbiter.
// A behavioural model tracks who holds the port and what memory should contain.
// Directed scenarios run first, followed by randomized traffic.
// Honours PUNC_ARB_STATS_EN when it is defined.
module tb_punc_mem_arbiter;

    localparam int BURST_MAX = 8;

    typedef struct packed {
        logic        req;
        logic        lock;
        logic        wr_en;
        logic [15:0] addr;
        logic [15:0] wdata;
    } port_drive_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    port_drive_t cDrv  = '0;
    port_drive_t dDrv  = '0;
    logic        cpu_stall;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr_en;
    logic [15:0] mem [0:65535];
`ifdef PUNC_ARB_STATS_EN
    logic [15:0] cpu_wait_cnt, dbg_wait_cnt;
`endif

    punc_mem_port_if #(.ADDR_W(16), .DATA_W(16)) cpu_bus ();
    punc_mem_port_if #(.ADDR_W(16), .DATA_W(16)) dbg_bus ();

    assign cpu_bus.req   = cDrv.req;
    assign cpu_bus.lock  = cDrv.lock;
    assign cpu_bus.wr_en = cDrv.wr_en;
    assign cpu_bus.addr  = cDrv.addr;
    assign cpu_bus.wdata = cDrv.wdata;
    assign dbg_bus.req   = dDrv.req;
    assign dbg_bus.lock  = dDrv.lock;
    assign dbg_bus.wr_en = dDrv.wr_en;
    assign dbg_bus.addr  = dDrv.addr;
    assign dbg_bus.wdata = dDrv.wdata;

    punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BURST_MAX(BURST_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu          (cpu_bus),
        .dbg          (dbg_bus),
        .cpu_stall    (cpu_stall),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wr_en    (mem_wr_en),
        .mem_rdata    (mem_rdata)
`ifdef PUNC_ARB_STATS_EN
        ,
        .cpu_wait_cnt (cpu_wait_cnt),
        .dbg_wait_cnt (dbg_wait_cnt)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Memory under the arbiter: asynchronous read, write on the rising edge
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    // Reference model state: owner 0 = nobody, 1 = CPU, 2 = debug
    int          refOwner = 0;
    int          refRun   = 0;
    int          refLast  = 2;
    int          refCpuWait = 0;
    int          refDbgWait = 0;
    logic [15:0] refMem [int];
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [15:0] refRead(input logic [15:0] a);
        if (refMem.exists(int'(a))) return refMem[int'(a)];
        return a ^ 16'h5A5A;
    endfunction

    // Advance the model over one rising edge, using the inputs held during the window that just ended.
    task automatic refStep();
        int  nxt;
        int  peer;
        bit  ownReq, ownLock, peerReq;
        if (!rst_n) begin
            refOwner = 0; refRun = 0; refLast = 2; refCpuWait = 0; refDbgWait = 0;
            return;
        end
        if (cDrv.req && refOwner != 1 && refCpuWait < 65535) refCpuWait++;
        if (dDrv.req && refOwner != 2 && refDbgWait < 65535) refDbgWait++;
        if (refOwner == 1 && cDrv.req && cDrv.wr_en) refMem[int'(cDrv.addr)] = cDrv.wdata;
        if (refOwner == 2 && dDrv.req && dDrv.wr_en) refMem[int'(dDrv.addr)] = dDrv.wdata;
        if (refOwner == 0) begin
            if (cDrv.req && dDrv.req) nxt = (refLast == 1) ? 2 : 1;
            else if (cDrv.req)        nxt = 1;
            else if (dDrv.req)        nxt = 2;
            else                      nxt = 0;
        end else begin
            ownReq  = (refOwner == 1) ? cDrv.req  : dDrv.req;
            ownLock = (refOwner == 1) ? cDrv.lock : dDrv.lock;
            peerReq = (refOwner == 1) ? dDrv.req  : cDrv.req;
            peer    = 3 - refOwner;
            if (ownReq && ownLock)                     nxt = refOwner;
            else if (!ownReq)                          nxt = peerReq ? peer : 0;
            else if (refRun + 1 >= BURST_MAX && peerReq) nxt = peer;
            else                                       nxt = refOwner;
        end
        if (nxt != refOwner) begin
            if (refOwner != 0) refLast = refOwner;
            refRun = 0;
        end else if (refOwner != 0) begin
            refRun++;
        end
        refOwner = nxt;
    endtask

    // Finish the previous window at the rising edge, drive the next window at the falling edge, then check.
    task automatic applyStimulus(input logic rst, input port_drive_t c, input port_drive_t d);
        logic expWr;
        @(posedge clk);
        refStep();
        @(negedge clk);
        rst_n = rst;
        cDrv  = c;
        dDrv  = d;
        #1;
        expWr = rst_n && ((refOwner == 1 && cDrv.req && cDrv.wr_en) ||
                          (refOwner == 2 && dDrv.req && dDrv.wr_en));
        checkOutput("cpu_gnt",   cpu_bus.gnt, refOwner == 1);
        checkOutput("dbg_gnt",   dbg_bus.gnt, refOwner == 2);
        checkOutput("cpu_stall", cpu_stall,   cDrv.req && refOwner != 1);
        checkOutput("mem_wr_en", mem_wr_en,   expWr);
        if (refOwner != 0) begin
            checkOutput("mem_addr",  mem_addr,  (refOwner == 2) ? dDrv.addr  : cDrv.addr);
            checkOutput("mem_wdata", mem_wdata, (refOwner == 2) ? dDrv.wdata : cDrv.wdata);
        end
        if (refOwner == 1 && cDrv.req && !cDrv.wr_en) checkOutput("cpu_rdata", cpu_bus.rdata, refRead(cDrv.addr));
        if (refOwner == 2 && dDrv.req && !dDrv.wr_en) checkOutput("dbg_rdata", dbg_bus.rdata, refRead(dDrv.addr));
`ifdef PUNC_ARB_STATS_EN
        checkOutput("cpu_wait_cnt", cpu_wait_cnt, refCpuWait);
        checkOutput("dbg_wait_cnt", dbg_wait_cnt, refDbgWait);
`endif
    endtask

    function automatic port_drive_t mk(input logic rq, input logic lk, input logic w, input logic [15:0] a, input logic [15:0] wd);
        port_drive_t p;
        p.req = rq; p.lock = lk; p.wr_en = w; p.addr = a; p.wdata = wd;
        return p;
    endfunction

    function automatic port_drive_t randPort();
        port_drive_t p;
        p.req   = ($urandom_range(0, 3) != 0);
        p.lock  = p.req && ($urandom_range(0, 2) == 0);
        p.wr_en = 1'($urandom_range(0, 1));
        p.addr  = 16'h0040 + 16'($urandom_range(0, 7));
        p.wdata = 16'($urandom);
        return p;
    endfunction

    port_drive_t idleP;
    port_drive_t nc, nd;
    bit          cHold, dHold;
    logic        rstVal;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        idleP = mk(0, 0, 0, 16'h0000, 16'h0000);

        $display("[TB] reset and first CPU read");
        applyStimulus(0, idleP, idleP);
        checkOutput("rst_cpu_gnt", cpu_bus.gnt, 0);
        checkOutput("rst_dbg_gnt", dbg_bus.gnt, 0);
        applyStimulus(1, mk(1, 0, 0, 16'h3000, 0), idleP);
        checkOutput("t1_gnt_cycle0", cpu_bus.gnt, 0);
        applyStimulus(1, mk(1, 0, 0, 16'h3000, 0), idleP);
        checkOutput("t1_gnt_cycle1", cpu_bus.gnt, 1);
        checkOutput("t1_rdata", cpu_bus.rdata, 16'h6A5A);
        checkOutput("t1_dbg_gnt", dbg_bus.gnt, 0);
        applyStimulus(1, idleP, idleP);

        $display("[TB] tie-break and handover");
        applyStimulus(0, idleP, idleP);
        applyStimulus(1, mk(1, 0, 0, 16'h0010, 0), mk(1, 0, 0, 16'h0020, 0));
        applyStimulus(1, mk(1, 0, 0, 16'h0010, 0), mk(1, 0, 0, 16'h0020, 0));
        checkOutput("t2_cpu_first", cpu_bus.gnt, 1);
        applyStimulus(1, idleP, mk(1, 0, 0, 16'h0020, 0));
        applyStimulus(1, idleP, mk(1, 0, 0, 16'h0020, 0));
        checkOutput("t2_dbg_next", dbg_bus.gnt, 1);
        applyStimulus(1, mk(1, 0, 0, 16'h0010, 0), idleP);
        applyStimulus(1, mk(1, 0, 0, 16'h0010, 0), idleP);
        checkOutput("t2_cpu_back", cpu_bus.gnt, 1);
        applyStimulus(1, idleP, idleP);
        applyStimulus(1, mk(1, 0, 0, 16'h0010, 0), mk(1, 0, 0, 16'h0020, 0));
        applyStimulus(1, mk(1, 0, 0, 16'h0010, 0), mk(1, 0, 0, 16'h0020, 0));
        checkOutput("t2_dbg_wins", dbg_bus.gnt, 1);
        checkOutput("t2_cpu_stall", cpu_stall, 1);

        $display("[TB] burst limit");
        applyStimulus(0, idleP, idleP);
        applyStimulus(1, mk(1, 0, 0, 16'h0100, 0), mk(1, 0, 0, 16'h0200, 0));
        for (int i = 0; i < BURST_MAX; i++) begin
            applyStimulus(1, mk(1, 0, 0, 16'h0100, 0), mk(1, 0, 0, 16'h0200, 0));
            checkOutput("t3_cpu_burst", cpu_bus.gnt, 1);
        end
        applyStimulus(1, mk(1, 0, 0, 16'h0100, 0), mk(1, 0, 0, 16'h0200, 0));
        checkOutput("t3_dbg_after", dbg_bus.gnt, 1);
        checkOutput("t3_cpu_stall", cpu_stall, 1);

        $display("[TB] lock");
        applyStimulus(0, idleP, idleP);
        applyStimulus(1, mk(1, 1, 0, 16'h0300, 0), mk(1, 0, 0, 16'h0200, 0));
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, mk(1, 1, 0, 16'h0300, 0), mk(1, 0, 0, 16'h0200, 0));
            checkOutput("t4_locked", cpu_bus.gnt, 1);
        end
        applyStimulus(1, mk(1, 0, 0, 16'h0300, 0), mk(1, 0, 0, 16'h0200, 0));
        checkOutput("t4_unlock_cycle", cpu_bus.gnt, 1);
        applyStimulus(1, mk(1, 0, 0, 16'h0300, 0), mk(1, 0, 0, 16'h0200, 0));
        checkOutput("t4_handover", dbg_bus.gnt, 1);

        $display("[TB] debug write then CPU read");
        applyStimulus(0, idleP, idleP);
        applyStimulus(1, idleP, mk(1, 0, 1, 16'h0040, 16'hBEEF));
        applyStimulus(1, idleP, mk(1, 0, 1, 16'h0040, 16'hBEEF));
        checkOutput("t5_wr_en", mem_wr_en, 1);
        applyStimulus(1, mk(1, 0, 0, 16'h0040, 0), idleP);
        checkOutput("t5_wr_once", mem_wr_en, 0);
        applyStimulus(1, mk(1, 0, 0, 16'h0040, 0), idleP);
        checkOutput("t5_rdata", cpu_bus.rdata, 16'hBEEF);

        $display("[TB] reset during granted write");
        applyStimulus(0, idleP, idleP);
        applyStimulus(1, mk(1, 0, 1, 16'h0050, 16'h1234), idleP);
        applyStimulus(1, mk(1, 0, 1, 16'h0050, 16'h1234), idleP);
        checkOutput("t6_wr_before", mem_wr_en, 1);
        applyStimulus(0, mk(1, 0, 1, 16'h0050, 16'h9999), idleP);
        checkOutput("t6_wr_blocked", mem_wr_en, 0);
        applyStimulus(1, idleP, idleP);
        checkOutput("t6_idle_gnt", cpu_bus.gnt, 0);
`ifdef PUNC_ARB_STATS_EN
        checkOutput("t6_cpu_wait0", cpu_wait_cnt, 0);
        checkOutput("t6_dbg_wait0", dbg_wait_cnt, 0);
`endif
        applyStimulus(1, mk(1, 0, 0, 16'h0050, 0), idleP);
        applyStimulus(1, mk(1, 0, 0, 16'h0050, 0), idleP);
        checkOutput("t6_rdata_kept", cpu_bus.rdata, 16'h1234);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            cHold  = rst_n && cDrv.req && (refOwner != 1);
            dHold  = rst_n && dDrv.req && (refOwner != 2);
            nc     = cHold ? cDrv : randPort();
            nd     = dHold ? dDrv : randPort();
            rstVal = ($urandom_range(0, 63) != 0);
            applyStimulus(rstVal, nc, nd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
